// File: rtl/frame_sender.sv
// Drains frame_len words from the frame buffer onto a valid/ready link. First word 2 cycles after start,
// then one word/cycle. Reads are throttled so buffered + in-flight words never exceed 2.
module frame_sender #(
    parameter int DATA_DEPTH = 1024,
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] frame_base,
    input  logic [ADDR_W:0]   frame_len,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              tx_last,
    output logic              frame_being_sent,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(DATA_DEPTH);
    localparam logic [ADDR_W:0] ONE   = (ADDR_W+1)'(1);

    state_t              state_q;
    logic                rd_en_q;
    logic                arr_q;
    logic                done_q;
    logic [ADDR_W-1:0]   rd_addr_q;
    logic [ADDR_W:0]     len_q;
    logic [ADDR_W:0]     issued_q;
    logic [ADDR_W:0]     sent_q;
    logic [1:0]          cnt_q;
    logic [DATA_W-1:0]   buf0_q;
    logic [DATA_W-1:0]   buf1_q;

    logic                start_ok;
    logic                xfer;
    logic                last_word;
    logic                rd_ok;
    logic [2:0]          occ;

    assign start_ok  = (state_q == IDLE) && start && (frame_len != '0) && (frame_len <= DEPTH);
    // A word on rd_data with an empty buffer goes straight out; it is captured if the sink stalls.
    assign tx_valid  = (cnt_q != 2'd0) || arr_q;
    assign tx_data   = (cnt_q == 2'd0 && arr_q) ? rd_data : buf0_q;
    assign last_word = (sent_q == len_q - ONE);
    assign tx_last   = tx_valid && last_word;
    assign xfer      = tx_valid && tx_ready;

    // Occupancy next cycle before any new read: buffered + arriving + in flight - leaving now.
    assign occ   = {1'b0, cnt_q} + {2'b0, arr_q} + {2'b0, rd_en_q} - {2'b0, xfer};
    assign rd_ok = (state_q == RUN) && (issued_q != len_q) && (occ < 3'd2);

    assign rd_en            = rd_en_q;
    assign rd_addr          = rd_addr_q;
    assign done             = done_q;
    assign frame_being_sent = (state_q != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            rd_en_q   <= 1'b0;
            arr_q     <= 1'b0;
            done_q    <= 1'b0;
            rd_addr_q <= '0;
            len_q     <= '0;
            issued_q  <= '0;
            sent_q    <= '0;
            cnt_q     <= 2'd0;
            buf0_q    <= '0;
            buf1_q    <= '0;
        end else begin
            done_q  <= 1'b0;
            rd_en_q <= 1'b0;
            arr_q   <= rd_en_q;
            if (xfer) begin
                sent_q <= sent_q + ONE;
            end

            case (cnt_q)
                2'd0: begin
                    if (arr_q && !xfer) begin
                        buf0_q <= rd_data;
                        cnt_q  <= 2'd1;
                    end
                end
                2'd1: begin
                    if (xfer) begin
                        if (arr_q) begin
                            buf0_q <= rd_data;
                        end else begin
                            cnt_q <= 2'd0;
                        end
                    end else if (arr_q) begin
                        buf1_q <= rd_data;
                        cnt_q  <= 2'd2;
                    end
                end
                default: begin
                    if (xfer) begin
                        buf0_q <= buf1_q;
                        cnt_q  <= 2'd1;
                    end
                end
            endcase

            case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        state_q   <= RUN;
                        len_q     <= frame_len;
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= frame_base;
                        issued_q  <= ONE;
                        sent_q    <= '0;
                    end
                end
                RUN: begin
                    if (rd_ok) begin
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= rd_addr_q + ADDR_W'(1);
                        issued_q  <= issued_q + ONE;
                    end else if (issued_q == len_q) begin
                        state_q <= FLUSH;
                    end
                end
                default: ;
            endcase

            if (state_q != IDLE && xfer && last_word) begin
                state_q <= IDLE;
                done_q  <= 1'b1;
            end
        end
    end

endmodule

// File: doc/frame_sender.md
# frame_sender

Streams a frame of 16-bit words out of the GPU's result frame buffer onto a valid/ready output link. It is the transmit-side counterpart of the program-loading path: that path fills `DATA_DEPTH` x 16-bit words into the GPU, and this block drains a buffer of the same shape back out. It owns the `frame_being_sent` status flag. It sits between the frame buffer's synchronous read port and the external output link.

## Interface
- `DATA_DEPTH`, 1024: number of words in the frame buffer; must be a power of two.
- `DATA_W`, 16: word width.
- `ADDR_W`, 10: buffer address width, log2(`DATA_DEPTH`).

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to send a frame.
- `frame_base`  in  `ADDR_W`  address of the first word; sampled with `start`.
- `frame_len`  in  `ADDR_W+1`  number of words, 1..`DATA_DEPTH`; sampled with `start`.
- `rd_en`  out  1  read strobe to the frame buffer.
- `rd_addr`  out  `ADDR_W`  read address.
- `rd_data`  in  `DATA_W`  read data, valid exactly 1 cycle after `rd_en`.
- `tx_data`  out  `DATA_W`  output word.
- `tx_valid`  out  1  `tx_data` is valid.
- `tx_ready`  in  1  sink accepts the word; a transfer occurs when `tx_valid && tx_ready`.
- `tx_last`  out  1  qualifies the final word of the frame.
- `frame_being_sent`  out  1  high while a frame is in progress.
- `done`  out  1  one-cycle pulse after the last transfer.

## Operation
- States:
  - IDLE: waiting for `start`.
  - RUN: issuing reads and sending words.
  - FLUSH: all reads issued; draining the buffer.
  - IDLE again after the last transfer.
- IDLE -> RUN on `start` when 1 <= `frame_len` <= `DATA_DEPTH`. The block latches `frame_base` and `frame_len` and clears its counters.
- `start` is ignored when `frame_len` is 0, when `frame_len` > `DATA_DEPTH`, or in any state other than IDLE. Ignored means no output changes.
- Read addresses are `(frame_base + n) mod DATA_DEPTH` for n = 0..`frame_len`-1. The address wraps from `DATA_DEPTH`-1 to 0 with no gap.
- A 2-entry output buffer feeds `tx_data`. A read is issued only when (buffered words + reads in flight) < 2, so the buffer can never overflow and `rd_data` is never dropped.
- RUN -> FLUSH when the read counter reaches `frame_len`.
- FLUSH -> IDLE on the transfer carrying `tx_last`.
- `tx_last` is asserted together with `tx_valid` only on word `frame_len`-1.
- Once `tx_valid` rises, `tx_valid`, `tx_data` and `tx_last` stay stable until the transfer occurs.
- Words leave in address order, with no loss and no duplication.
- `frame_being_sent` is 1 in RUN and FLUSH, and 0 otherwise.
- `done` pulses in the cycle after the last transfer. `frame_being_sent` is 0 in that same cycle.
- A `start` in the `done` cycle is accepted, because the state is IDLE in that cycle.
- Reset mid-frame: the block goes to IDLE immediately and the buffer empties. No further `rd_en`, `tx_valid` or `done` is produced for the aborted frame.

## Timing
- Reset values: `rd_en`=0, `rd_addr`=0, `tx_data`=0, `tx_valid`=0, `tx_last`=0, `frame_being_sent`=0, `done`=0.
- Counters use `ADDR_W+1` bits. Address arithmetic is mod 2^`ADDR_W`.
- `start` sampled at edge T:
  - `frame_being_sent`=1 and `rd_en`=1 with `rd_addr`=`frame_base` from T+1.
  - First `tx_valid` at T+2.
- With `tx_ready` held at 1 there is one word per cycle. Word k transfers at T+2+k. The last transfer is at T+1+`frame_len`. `done` is at T+2+`frame_len`.
- A `tx_ready` deassertion stalls reads within 1 cycle, because of the 2-entry limit.
- Restart: `start` at T+2+`frame_len` gives a new first word at T+4+`frame_len`.

## Test plan
- **Full frame:** buffer[i]=i, `frame_base`=0, `frame_len`=1024, `tx_ready`=1.
  - Data 0..1023, one per cycle, first at T+2.
  - `tx_last` only on 1023.
  - `done` at T+1026; `frame_being_sent` high T+1..T+1025.
- **Wrap-around:** `frame_base`=1020, `frame_len`=8.
  - `rd_addr` sequence 1020,1021,1022,1023,0,1,2,3.
  - Data is in the same order; `tx_last` on the 8th word.
- **Backpressure:** `frame_len`=16, `tx_ready` random at about 50%.
  - Exactly 16 transfers in order.
  - `tx_data` and `tx_valid` unchanged during every stall.
  - Never more than 2 words buffered or in flight.
- **Illegal or overlapping start:**
  - `frame_len`=0 -> no activity, `frame_being_sent` stays 0.
  - `frame_len`=1025 -> same result.
  - `start` mid-frame -> ignored; the current frame completes unchanged.
- **Single word and back-to-back:** `frame_len`=1, then `start` again in the `done` cycle.
  - One word with `tx_last`=1, `done` at T+3.
  - Second frame's first word at T+5.
- **Reset mid-frame:** `reset`=0 for 2 cycles during word 5 of 32.
  - All outputs are 0 while `reset` is low.
  - No `done` pulse after release.
  - The next `start` runs a clean frame from word 0.
